booth_mul_arbiter: RTL and testbench

Shares one combinational `boothMultiplier` (signed WIDTH x WIDTH -> 2*WIDTH) between N_REQ requesters. Round-robin arbitration, valid/ready handshake per requester, registered operands and result, one shared response channel tagged with the requester ID. Sits between client blocks and the single multiplier instance, so the multiplier has no back-to-back combinational path to any client.

---
 rtl/booth_pkg.sv | 6 +
 rtl/boothMultiplier.sv | 26 ++
 rtl/rr_arbiter.sv | 22 ++
 rtl/booth_mul_arbiter.sv | 73 +++++++
 tb/tb_booth_mul_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and default sizes for the booth multiplier arbiter
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
  localparam int WIDTH_DEF = 32;
  localparam int N_REQ_DEF = 4;
endpackage

// File: rtl/boothMultiplier.sv
// boothMultiplier: combinational radix-4 Booth signed multiplier, full 2*WIDTH product
module boothMultiplier #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] product
);
  localparam int G = (WIDTH + 1) / 2;
  logic [WIDTH+1:0]   ye;
  logic [2*WIDTH-1:0] xe, pp;
  assign ye = {y[WIDTH-1], y, 1'b0};
  assign xe = {{WIDTH{x[WIDTH-1]}}, x};
  // Partial products wrap modulo 2^(2*WIDTH); the true product always fits, so the sum is exact.
  always_comb begin
    product = '0;
    pp = '0;
    for (int g = 0; g < G; g++) begin
      pp = (ye[2*g +: 3] == 3'b001 || ye[2*g +: 3] == 3'b010) ? xe :
           (ye[2*g +: 3] == 3'b011) ? (xe << 1) :
           (ye[2*g +: 3] == 3'b100) ? -(xe << 1) :
           (ye[2*g +: 3] == 3'b101 || ye[2*g +: 3] == 3'b110) ? -xe : '0;
      product = product + (pp << (2 * g));
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or above ptr_i, wrapping
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);
  // Descending scan so the closest request to the pointer is written last and wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
        idx_o = ID_W'((int'(ptr_i) + k) % N_REQ);
        gnt_o = N_REQ'(1) << ((int'(ptr_i) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one registered boothMultiplier among N_REQ requesters
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [2*WIDTH-1:0]     resp_product,
  output logic                   busy
);
  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
  logic [WIDTH-1:0]     op_x_q, op_x_d, op_y_q, op_y_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, prod;
  logic [N_REQ-1:0]     gnt;
  logic                 accept;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i(req_valid), .ptr_i(rr_ptr_q), .gnt_o(gnt), .idx_o(gnt_idx)
  );

  boothMultiplier #(.WIDTH(WIDTH)) u_mul (.x(op_x_q), .y(op_y_q), .product(prod));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_x_q   <= '0;
      op_y_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_x_q   <= op_x_d;
      op_y_q   <= op_y_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE) ? gnt : '0;
    accept    = |(req_valid & req_ready);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = accept ? CALC : IDLE;
      CALC:    state_d = RESP;
      RESP:    state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    rr_ptr_d = accept ? ((int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    id_d     = accept ? gnt_idx : id_q;
    op_x_d   = accept ? req_x[int'(gnt_idx)*WIDTH +: WIDTH] : op_x_q;
    op_y_d   = accept ? req_y[int'(gnt_idx)*WIDTH +: WIDTH] : op_y_q;
    prod_d   = (state_q == CALC) ? prod : prod_q;
  end

  assign resp_valid   = (state_q == RESP);
  assign resp_id      = id_q;
  assign resp_product = prod_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed vectors with a response scoreboard for booth_mul_arbiter
module tb_booth_mul_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_x, req_y;
  logic         resp_valid, resp_ready, busy;
  logic [1:0]   resp_id;
  logic [63:0]  resp_product;
  int           total = 0, bad = 0, resp_cnt = 0, cyc = 0;
  logic [1:0]   exp_id[$];
  logic [63:0]  exp_p[$];
  int           resp_cyc[$];

  booth_mul_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_id.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got id %0d product %0h want none", resp_id, resp_product);
      end else begin
        chk("resp_id", 64'(resp_id), 64'(exp_id.pop_front()));
        chk("resp_product", resp_product, exp_p.pop_front());
      end
      resp_cnt++;
      resp_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_resp(input int target, input string name);
    for (int i = 0; i < 40 && resp_cnt < target; i++) tick();
    chk(name, 64'(resp_cnt), 64'(target));
  endtask

  task automatic do_op(input int id, input logic [31:0] x, input logic [31:0] y, input logic [63:0] p);
    int n;
    n = resp_cnt;
    exp_id.push_back(2'(id));
    exp_p.push_back(p);
    req_x[id*32 +: 32] = x;
    req_y[id*32 +: 32] = y;
    req_valid = 4'(1 << id);
    @(negedge clk);
    chk("op_grant", 64'(req_ready), 64'(1 << id));
    tick();
    req_valid = '0;
    wait_resp(n + 1, "op_done");
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int base, n;
    rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_id", 64'(resp_id), 0);
    chk("rst_resp_product", resp_product, 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    // single op with latency checks
    tick();
    req_x[31:0] = 32'd2; req_y[31:0] = 32'hFFFF_FFFF; req_valid = 4'b0001;
    exp_id.push_back(2'd0); exp_p.push_back(-64'sd2);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("calc_busy", 64'(busy), 1);
    chk("calc_resp_valid", 64'(resp_valid), 0);
    chk("calc_ready", 64'(req_ready), 0);
    tick();
    @(negedge clk);
    chk("resp_valid_k2", 64'(resp_valid), 1);
    tick();
    @(negedge clk);
    chk("single_idle", 64'(busy), 0);
    chk("single_cnt", 64'(resp_cnt), 1);
    // round robin from reset: ids 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_x[i*32 +: 32] = 32'(i + 1);
      req_y[i*32 +: 32] = 32'(-65535);
    end
    for (int i = 0; i < 5; i++) begin
      exp_id.push_back(2'(i % 4));
      exp_p.push_back(64'(-65535 * ((i % 4) + 1)));
    end
    base = resp_cyc.size();
    n = resp_cnt;
    req_valid = 4'b1111;
    for (int i = 0; i < 40 && resp_cnt < n + 5; i++) tick();
    req_valid = '0;
    chk("rr_cnt", 64'(resp_cnt), 64'(n + 5));
    for (int i = 1; i < 5; i++)
      if (resp_cyc.size() > base + i) chk("rr_interval", 64'(resp_cyc[base+i] - resp_cyc[base+i-1]), 3);
    // backpressure
    tick();
    resp_ready = 1'b0;
    req_x[31:0] = 32'(-65535); req_y[31:0] = 32'd65535; req_valid = 4'b0001;
    exp_id.push_back(2'd0); exp_p.push_back(-64'sd4294836225);
    n = resp_cnt;
    @(negedge clk);
    chk("bp_grant", 64'(req_ready), 64'b0001);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 1);
      chk("bp_id", 64'(resp_id), 0);
      chk("bp_product", resp_product, -64'sd4294836225);
      chk("bp_req_ready", 64'(req_ready), 0);
    end
    tick();
    req_valid = '0;
    resp_ready = 1'b1;
    wait_resp(n + 1, "bp_done");
    // extremes
    do_op(3, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op(3, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    do_op(3, 32'd7, 32'd0, 64'd0);
    // reset while in CALC discards the operation
    n = resp_cnt;
    req_x[31:0] = 32'd3; req_y[31:0] = 32'd5; req_valid = 4'b0001;
    @(negedge clk);
    chk("rc_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rc_busy", 64'(busy), 0);
    chk("rc_resp_valid", 64'(resp_valid), 0);
    req_valid = 4'b0011;
    #1;
    chk("rc_ptr_zero", 64'(req_ready), 64'b0001);
    req_valid = '0;
    repeat (6) tick();
    chk("rc_no_resp", 64'(resp_cnt), 64'(n));
    // sparse requests with pointer wrap
    do_op(2, 32'd4, 32'(-3), -64'sd12);
    do_op(1, 32'(-5), 32'(-6), 64'd30);
    chk("queue_empty", 64'(exp_id.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
